// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-store FIFO with same-word coalescing, load forwarding and req/ack drain to memory
module store_write_buffer #(
  parameter int DEPTH = 4,
  localparam int PTRW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            st_valid,
  input  logic [31:0]     st_addr,
  input  logic [3:0]      st_byteen,
  input  logic [31:0]     st_wdata,
  output logic            st_ready,
  input  logic            ld_valid,
  input  logic [31:0]     ld_addr,
  output logic [3:0]      ld_hit_byteen,
  output logic [31:0]     ld_fwd_data,
  output logic            mem_req,
  output logic [31:0]     mem_addr,
  output logic [3:0]      mem_byteen,
  output logic [31:0]     mem_wdata,
  input  logic            mem_ack,
  output logic [PTRW:0]   count,
  output logic            empty
);
  logic [29:0] addr_q [DEPTH];
  logic [3:0] be_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTRW-1:0] head, tail, young, idx;
  logic acc, merge, pop;
  logic [31:0] merged;
  assign young = tail - PTRW'(1);
  assign st_ready = count != (PTRW+1)'(DEPTH);
  assign empty = count == '0;
  assign mem_req = !empty;
  assign mem_addr = mem_req ? {addr_q[head], 2'b00} : '0;
  assign mem_byteen = mem_req ? be_q[head] : '0;
  assign mem_wdata = mem_req ? data_q[head] : '0;
  assign acc = st_valid && st_ready && |st_byteen;
  assign merge = count > (PTRW+1)'(1) && addr_q[young] == st_addr[31:2] && young != head;
  assign pop = mem_req && mem_ack;
  always_comb begin
    merged = data_q[young];
    for (int l = 0; l < 4; l++)
      if (st_byteen[l]) merged[8*l +: 8] = st_wdata[8*l +: 8];
  end
  always_comb begin
    ld_hit_byteen = '0;
    ld_fwd_data = '0;
    idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTRW'(i);
      if (ld_valid && valid_q[idx] && addr_q[idx] == ld_addr[31:2])
        for (int l = 0; l < 4; l++)
          if (be_q[idx][l]) begin
            ld_hit_byteen[l] = 1'b1;
            ld_fwd_data[8*l +: 8] = data_q[idx][8*l +: 8];
          end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        be_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (pop) begin
        valid_q[head] <= 1'b0;
        head <= head + PTRW'(1);
      end
      if (acc && merge) begin
        be_q[young] <= be_q[young] | st_byteen;
        data_q[young] <= merged;
      end else if (acc) begin
        valid_q[tail] <= 1'b1;
        addr_q[tail] <= st_addr[31:2];
        be_q[tail] <= st_byteen;
        data_q[tail] <= st_wdata;
        tail <= tail + PTRW'(1);
      end
      count <= count + (PTRW+1)'(acc && !merge) - (PTRW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: vector table plus corner sequences, with a queue model scoring every memory write
module tb_store_write_buffer;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic st_valid = 1'b0, ld_valid = 1'b0, mem_ack = 1'b0;
  logic [31:0] st_addr = '0, st_wdata = '0, ld_addr = '0;
  logic [3:0] st_byteen = '0;
  logic st_ready, mem_req, empty;
  logic [3:0] ld_hit_byteen, mem_byteen;
  logic [31:0] ld_fwd_data, mem_addr, mem_wdata;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;
  store_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_byteen(st_byteen), .st_wdata(st_wdata), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit_byteen(ld_hit_byteen), .ld_fwd_data(ld_fwd_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_byteen(mem_byteen), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .count(count), .empty(empty)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [29:0] a;
    logic [3:0] b;
    logic [31:0] d;
  } ent_t;
  ent_t mq[$];
  typedef struct {
    logic sv;
    logic [31:0] sa;
    logic [3:0] sb;
    logic [31:0] sd;
    logic ack;
    logic lv;
    logic [31:0] la;
    logic [2:0] ecnt;
    logic erdy;
    logic [3:0] ehit;
    logic [31:0] efwd;
  } vec_t;
  vec_t v[14];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  always @(posedge clk) begin : model
    ent_t e;
    logic [31:0] m;
    int k;
    if (reset) begin
      if (st_valid && mq.size() < DEPTH && st_byteen != 4'b0) begin
        m = {{8{st_byteen[3]}}, {8{st_byteen[2]}}, {8{st_byteen[1]}}, {8{st_byteen[0]}}};
        k = mq.size() - 1;
        if (mq.size() >= 2 && mq[k].a == st_addr[31:2]) begin
          e = mq[k];
          e.b = e.b | st_byteen;
          e.d = (e.d & ~m) | (st_wdata & m);
          mq[k] = e;
        end else begin
          e.a = st_addr[31:2];
          e.b = st_byteen;
          e.d = st_wdata;
          mq.push_back(e);
        end
      end
      if (mem_ack && mq.size() > 0) void'(mq.pop_front());
    end
  end
  always @(negedge reset) mq.delete();
  always @(negedge clk) begin
    if (reset) begin
      chk("mon_count", 32'(count), 32'(mq.size()));
      chk("mon_mem_req", 32'(mem_req), 32'(mq.size() != 0));
      if (mem_req && mem_ack && mq.size() > 0) begin
        chk("sb_addr", mem_addr, {mq[0].a, 2'b00});
        chk("sb_byteen", 32'(mem_byteen), 32'(mq[0].b));
        chk("sb_wdata", mem_wdata, mq[0].d);
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic idle();
    st_valid = 1'b0;
    st_addr = '0;
    st_byteen = '0;
    st_wdata = '0;
    ld_valid = 1'b0;
    ld_addr = '0;
    mem_ack = 1'b0;
  endtask
  task automatic store(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr = a;
    st_byteen = b;
    st_wdata = d;
  endtask
  task automatic drain();
    int n = 0;
    idle();
    mem_ack = 1'b1;
    while (!empty && n < 20) begin
      cyc();
      n++;
    end
    chk("drain_done", 32'(empty), 32'd1);
    mem_ack = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    v[0]  = '{1'b1, 32'h100, 4'b0001, 32'h11,       1'b0, 1'b0, 32'h0,   3'd0, 1'b1, 4'h0, 32'h0};
    v[1]  = '{1'b1, 32'h200, 4'b1111, 32'hAAAAAAAA, 1'b0, 1'b0, 32'h0,   3'd1, 1'b1, 4'h0, 32'h0};
    v[2]  = '{1'b1, 32'h203, 4'b1000, 32'h55000000, 1'b0, 1'b0, 32'h0,   3'd2, 1'b1, 4'h0, 32'h0};
    v[3]  = '{1'b1, 32'h101, 4'b0010, 32'h00002200, 1'b0, 1'b0, 32'h0,   3'd2, 1'b1, 4'h0, 32'h0};
    v[4]  = '{1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b1, 32'h202, 3'd3, 1'b1, 4'hF, 32'h55AAAAAA};
    v[5]  = '{1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b1, 32'h100, 3'd3, 1'b1, 4'h3, 32'h00002211};
    v[6]  = '{1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 32'h100, 3'd3, 1'b1, 4'h0, 32'h0};
    v[7]  = '{1'b1, 32'h300, 4'b0011, 32'h00001234, 1'b0, 1'b0, 32'h0,   3'd3, 1'b1, 4'h0, 32'h0};
    v[8]  = '{1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 32'h0,   3'd4, 1'b0, 4'h0, 32'h0};
    v[9]  = '{1'b1, 32'h400, 4'b1111, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,   3'd4, 1'b0, 4'h0, 32'h0};
    v[10] = '{1'b1, 32'h304, 4'b1111, 32'h04040404, 1'b1, 1'b0, 32'h0,   3'd3, 1'b1, 4'h0, 32'h0};
    v[11] = '{1'b1, 32'h300, 4'b0010, 32'h0000AB00, 1'b0, 1'b0, 32'h0,   3'd3, 1'b1, 4'h0, 32'h0};
    v[12] = '{1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b1, 32'h302, 3'd4, 1'b0, 4'h3, 32'h0000AB34};
    v[13] = '{1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b1, 32'h308, 3'd4, 1'b0, 4'h0, 32'h0};
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_byteen", 32'(mem_byteen), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    ld_valid = 1'b1;
    ld_addr = 32'h100;
    #1;
    chk("rst_ld_hit", 32'(ld_hit_byteen), 32'h0);
    chk("rst_ld_fwd", ld_fwd_data, 32'h0);
    ld_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    for (int r = 0; r < 14; r++) begin
      st_valid = v[r].sv;
      st_addr = v[r].sa;
      st_byteen = v[r].sb;
      st_wdata = v[r].sd;
      mem_ack = v[r].ack;
      ld_valid = v[r].lv;
      ld_addr = v[r].la;
      #1;
      chk($sformatf("v%0d_count", r), 32'(count), 32'(v[r].ecnt));
      chk($sformatf("v%0d_st_ready", r), 32'(st_ready), 32'(v[r].erdy));
      chk($sformatf("v%0d_ld_hit", r), 32'(ld_hit_byteen), 32'(v[r].ehit));
      chk($sformatf("v%0d_ld_fwd", r), ld_fwd_data, v[r].efwd);
      cyc();
    end
    drain();
    idle();
    store(32'h1004, 4'b0011, 32'h0000BEEF);
    #1;
    chk("single_lat0_req", 32'(mem_req), 32'd0);
    cyc();
    idle();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("single_req", 32'(mem_req), 32'd1);
      chk("single_addr", mem_addr, 32'h1004);
      chk("single_byteen", 32'(mem_byteen), 32'h3);
      chk("single_wdata", mem_wdata, 32'h0000BEEF);
      cyc();
    end
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    #1;
    chk("single_empty_after_ack", 32'(empty), 32'd1);
    mem_ack = 1'b1;
    cyc();
    cyc();
    #1;
    chk("empty_ack_count", 32'(count), 32'd0);
    chk("empty_ack_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      store(32'h2000 + 32'(k * 4), 4'b1111, $urandom);
      cyc();
    end
    idle();
    mem_ack = 1'b1;
    for (int k = 3; k > 0; k--) begin
      #1;
      chk("b2b_count", 32'(count), 32'(k));
      chk("b2b_req", 32'(mem_req), 32'd1);
      cyc();
    end
    #1;
    chk("b2b_final_count", 32'(count), 32'd0);
    chk("b2b_final_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      store(32'h3000 + 32'(k * 4), 4'b0101, 32'h00FF00FF);
      cyc();
    end
    idle();
    #1;
    chk("rstmid_pre_req", 32'(mem_req), 32'd1);
    chk("rstmid_pre_count", 32'(count), 32'd3);
    reset = 1'b0;
    #1;
    chk("rstmid_req", 32'(mem_req), 32'd0);
    chk("rstmid_count", 32'(count), 32'd0);
    chk("rstmid_empty", 32'(empty), 32'd1);
    chk("rstmid_ready", 32'(st_ready), 32'd1);
    reset = 1'b1;
    mem_ack = 1'b1;
    cyc();
    cyc();
    #1;
    chk("rstmid_post_count", 32'(count), 32'd0);
    chk("rstmid_post_req", 32'(mem_req), 32'd0);
    idle();
    store(32'h5000, 4'b1111, 32'hCAFEF00D);
    cyc();
    idle();
    #1;
    chk("post_rst_addr", mem_addr, 32'h5000);
    chk("post_rst_wdata", mem_wdata, 32'hCAFEF00D);
    drain();
    chk("sb_drained", 32'(mq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_write_buffer.md
# store_write_buffer

Posted-store buffer that sits directly downstream of the memory-stage store byte-enable/lane-alignment logic. It accepts lane-aligned stores (word address, 4-bit byte enable, 32-bit data) from the M stage and queues them in a FIFO. It drains the queue to the data-memory bus through a req/ack handshake. It also coalesces same-word stores and forwards pending bytes to loads, so the pipeline stalls only when the buffer is full.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- PTRW, log2(DEPTH), pointer width (derived, not overridden)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- st_valid  in  1  store request from M stage this cycle
- st_addr  in  32  store byte address; only [31:2] used
- st_byteen  in  4  byte lanes to write; 0 is treated as no store
- st_wdata  in  32  lane-aligned store data
- st_ready  out  1  buffer can accept a store this cycle
- ld_valid  in  1  load in M stage probing the buffer
- ld_addr  in  32  load byte address; only [31:2] used
- ld_hit_byteen  out  4  lanes of the load word covered by pending stores
- ld_fwd_data  out  32  youngest pending data per covered lane; 0 in uncovered lanes
- mem_req  out  1  head entry presented to memory
- mem_addr  out  32  {head word address, 2'b00}
- mem_byteen  out  4  head byte enable
- mem_wdata  out  32  head data
- mem_ack  in  1  memory accepts the presented write this cycle
- count  out  PTRW+1  occupied entries
- empty  out  1  count == 0

## Operation

- Entry fields: valid, word address [31:2], byteen[3:0], data[31:0]. FIFO uses head/tail pointers with wrap-around modulo DEPTH.
- st_ready = (count != DEPTH). This signal is purely combinational from state; it does not depend on mem_ack. A full buffer refuses stores even in an ack cycle.
- A store is accepted when st_valid && st_ready && st_byteen != 0.
- **Coalescing.** An accepted store merges into the youngest entry (tail−1) when all of the following hold:
  - count ≥ 2, and
  - the youngest entry's word address equals st_addr[31:2], and
  - the youngest entry is not the head.
  - Merge rule: byteen |= st_byteen; each lane with st_byteen[i]=1 takes st_wdata lane i. Count is unchanged.
  - Otherwise the store is written at tail, and tail and count increment.
- **Head entry.** The head entry is never modified while it is presented. mem_addr, mem_byteen and mem_wdata stay stable while mem_req=1 until mem_ack.
- mem_req = !empty. mem_ack is ignored when mem_req=0.
- On mem_ack with mem_req=1, the head is released: head increments and count decrements.
- Simultaneous non-coalescing enqueue and dequeue leave count unchanged.
- **Forwarding.** Combinational, over all valid entries including the head. For each lane, the youngest entry with matching word address and that lane enabled supplies the byte.
  - ld_hit_byteen is the OR of matching lanes.
  - The downstream merge takes covered lanes from ld_fwd_data and uncovered lanes from memory read data.
  - When ld_valid=0, ld_hit_byteen=0 and ld_fwd_data=0.
- A store accepted this cycle is not visible to forwarding until the next cycle. The pipeline never has a load and a store in M simultaneously.

## Timing

- Reset (reset=0, asynchronous): head=tail=0, count=0, all entry valid bits cleared. Outputs: empty=1, mem_req=0, mem_addr/mem_byteen/mem_wdata=0, st_ready=1, ld_hit_byteen=0, ld_fwd_data=0.
- Reset asserted mid-transaction drops mem_req immediately and discards all pending stores.
- Enqueue-to-mem_req latency: 1 cycle. A store accepted at edge N into an empty buffer raises mem_req after edge N.
- Back-to-back drain: with mem_ack held high, one entry retires per cycle, and mem_req stays high while entries remain.
- Full (count=DEPTH): st_ready=0. A pop at edge N makes st_ready=1 in the cycle after edge N.
- Pointer wrap: tail or head at DEPTH−1 increments to 0.
- Empty with mem_ack=1: no state change.

## Test plan

- **Single store:** st 0x0000_1004, byteen 4'b0011, data 0x0000_BEEF; mem_ack low 3 cycles then high 1 cycle → mem_req high from next cycle with mem_addr 0x1004, byteen 0011, wdata 0x0000BEEF, fields stable; empty=1 after the ack edge.
- **Coalesce:**
  - st A=0x100 byteen 0001 data 0x11, then st 0x200 byteen 1111 data 0xAAAAAAAA, then st 0x203 byteen 1000 data 0x55000000, no ack → count=2; entry1 byteen 1111, data 0x55AAAAAA.
  - Then st 0x101 byteen 0010 → new entry, count=3 (the 0x100 entry is head and is not merged).
- **Full/backpressure with DEPTH=4:** 4 distinct-word stores, no ack → st_ready=0; 5th store held; mem_ack for 1 cycle → st_ready=1 next cycle; 5th accepted and stored in slot 0 (wrap).
- **Forwarding:**
  - Pending 0x300 byteen 0011 data 0x00001234, then 0x304 and 0x300 byteen 0010 data 0x0000AB00.
  - Load 0x302 → ld_hit_byteen 0011, ld_fwd_data 0x0000AB34.
  - Load 0x308 → hit 0000, data 0.
- **Reset mid-drain:** 3 entries pending, mem_req high, reset low for 1 ns between edges → mem_req=0 and count=0 immediately; after release, mem_ack high produces no pop.
